// File: rtl/tcp_hs_pkg.sv
// Shared definitions for the TCP handshake FSMs (client and server).
//   SEQ_W_DEF      : default sequence/ack number width
//   FLAG_*         : bit positions of the segment flags in a packed flag vector
//   hs_state_t     : handshake state encoding, common to both ends
package tcp_hs_pkg;

   localparam int SEQ_W_DEF = 8;

   localparam int FLAG_SYN = 0;
   localparam int FLAG_ACK = 1;
   localparam int FLAG_RST = 2;
   localparam int FLAG_W   = 3;

   // LISTEN and SYN_RCVD are only reached by the server side.
   typedef enum logic [2:0] {
      ST_CLOSED      = 3'd0,
      ST_LISTEN      = 3'd1,
      ST_SYN_SENT    = 3'd2,
      ST_SYN_RCVD    = 3'd3,
      ST_ACK_SEND    = 3'd4,
      ST_ESTABLISHED = 3'd5,
      ST_FAILED      = 3'd6
   } hs_state_t;

endpackage

// File: rtl/tcp_hs_timer.sv
// Loadable down-counter used for handshake retransmit timeouts.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (wins over counting)
//   load_val   : reload value
//   en         : count down this cycle
//   expire     : combinational pulse on the last counted cycle (count==1 while enabled)
module tcp_hs_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expire
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)                      count <= '0;
      else if (load)                  count <= load_val;
      else if (en && (count != '0))   count <= count - 1'b1;
   end

   // A load of N produces expire on the N-th enabled cycle after the load.
   assign expire = en && (count == W'(1));

endmodule

// File: rtl/tcp_client_handshake.sv
// Client (active-open) side of the TCP three-way handshake.
//   clk, reset              : clock, synchronous active-high reset
//   open_req                : start a connection (honoured in CLOSED / FAILED)
//   rx_valid, rx_syn/ack/rst: received segment strobe and flags
//   rx_seq, rx_ack_num      : received sequence / acknowledgement numbers
//   send_syn, send_ack      : one-cycle transmit pulses
//   tx_seq, tx_ack_num      : numbers for the current pulse, held between pulses
//   established, fail       : connection-open and retries-exhausted levels
module tcp_client_handshake #(
   parameter int SEQ_W       = tcp_hs_pkg::SEQ_W_DEF,
   parameter int CLIENT_ISN  = 100,
   parameter int TIMEOUT_CYC = 16,
   parameter int MAX_RETRY   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             open_req,
   input  logic             rx_valid,
   input  logic             rx_syn,
   input  logic             rx_ack,
   input  logic             rx_rst,
   input  logic [SEQ_W-1:0] rx_seq,
   input  logic [SEQ_W-1:0] rx_ack_num,
   output logic             send_syn,
   output logic             send_ack,
   output logic [SEQ_W-1:0] tx_seq,
   output logic [SEQ_W-1:0] tx_ack_num,
   output logic             established,
   output logic             fail
);
   import tcp_hs_pkg::*;

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [SEQ_W-1:0] ISN     = SEQ_W'(CLIENT_ISN);
   localparam logic [SEQ_W-1:0] ISN_P1  = ISN + 1'b1;   // wraps mod 2^SEQ_W
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYC);

   hs_state_t         state, state_n;
   logic [RTY_W-1:0]  retry;
   logic [SEQ_W-1:0]  srv_seq, srv_seq_n;
   logic [FLAG_W-1:0] rx_flags;
   logic              match, rst_hit, expire, tmr_en, tmr_load;
   logic              syn_d, ack_d, retry_clr, retry_inc;

   always_comb begin
      rx_flags           = '0;
      rx_flags[FLAG_SYN] = rx_syn;
      rx_flags[FLAG_ACK] = rx_ack;
      rx_flags[FLAG_RST] = rx_rst;
   end

   assign match   = rx_valid & rx_flags[FLAG_SYN] & rx_flags[FLAG_ACK] & (rx_ack_num == ISN_P1);
   assign rst_hit = rx_valid & rx_flags[FLAG_RST] & (state != ST_CLOSED);
   assign tmr_en  = (state == ST_SYN_SENT);

   tcp_hs_timer #(.W(CNT_W)) u_tmr (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (TMO),
      .en       (tmr_en),
      .expire   (expire)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_CLOSED;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      syn_d     = 1'b0;
      ack_d     = 1'b0;
      tmr_load  = 1'b0;
      retry_clr = 1'b0;
      retry_inc = 1'b0;
      srv_seq_n = srv_seq;
      unique case (state)
         ST_CLOSED, ST_FAILED: begin
            if (open_req) begin
               state_n   = ST_SYN_SENT;
               syn_d     = 1'b1;
               tmr_load  = 1'b1;
               retry_clr = 1'b1;
            end
         end
         ST_SYN_SENT: begin
            // A match beats a coincident timer expiry.
            if (match) begin
               state_n   = ST_ACK_SEND;
               ack_d     = 1'b1;
               srv_seq_n = rx_seq;
            end else if (expire) begin
               if (retry < RTY_MAX) begin
                  syn_d     = 1'b1;
                  tmr_load  = 1'b1;
                  retry_inc = 1'b1;
               end else begin
                  state_n = ST_FAILED;
               end
            end
         end
         ST_ACK_SEND:    state_n = ST_ESTABLISHED;
         ST_ESTABLISHED: state_n = ST_ESTABLISHED;
         default:        state_n = ST_CLOSED;
      endcase
      // RST overrides everything decided above.
      if (rst_hit) begin
         state_n   = ST_CLOSED;
         syn_d     = 1'b0;
         ack_d     = 1'b0;
         tmr_load  = 1'b0;
         retry_inc = 1'b0;
         retry_clr = 1'b0;
         srv_seq_n = srv_seq;
      end
   end

   // Outputs are registered from the next-state decision so each pulse lines up
   // with the cycle the FSM occupies the corresponding state.
   always_ff @(posedge clk) begin
      if (reset) begin
         retry       <= '0;
         srv_seq     <= '0;
         send_syn    <= 1'b0;
         send_ack    <= 1'b0;
         tx_seq      <= '0;
         tx_ack_num  <= '0;
         established <= 1'b0;
         fail        <= 1'b0;
      end else begin
         if (retry_clr)      retry <= '0;
         else if (retry_inc) retry <= retry + 1'b1;
         srv_seq  <= srv_seq_n;
         send_syn <= syn_d;
         send_ack <= ack_d;
         if (syn_d) begin
            tx_seq     <= ISN;
            tx_ack_num <= '0;
         end else if (ack_d) begin
            tx_seq     <= ISN_P1;
            tx_ack_num <= srv_seq_n + 1'b1;
         end
         established <= (state_n == ST_ESTABLISHED);
         fail        <= (state_n == ST_FAILED);
      end
   end

endmodule

// File: tb/tb_tcp_client_handshake.sv
// Bench for tcp_client_handshake: a scoreboard of expected send_* pulses
// (kind, edge number, tx_seq, tx_ack_num) checked by a monitor, plus
// per-scenario level checks.
module tb_tcp_client_handshake;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       open_req = 1'b0, open_req2 = 1'b0;
   logic       rx_valid = 1'b0, rx_syn = 1'b0, rx_ack = 1'b0, rx_rst = 1'b0;
   logic [7:0] rx_seq = '0, rx_ack_num = '0;
   logic       send_syn, send_ack, established, fail;
   logic [7:0] tx_seq, tx_ack_num;
   logic       w_send_syn, w_send_ack, w_established, w_fail;
   logic [7:0] w_tx_seq, w_tx_ack_num;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      bit         is_ack;
      int         cyc;
      logic [7:0] seq;
      logic [7:0] ack;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   tcp_client_handshake #(.SEQ_W(8), .CLIENT_ISN(100), .TIMEOUT_CYC(16), .MAX_RETRY(3)) dut (
      .clk(clk), .reset(reset), .open_req(open_req),
      .rx_valid(rx_valid), .rx_syn(rx_syn), .rx_ack(rx_ack), .rx_rst(rx_rst),
      .rx_seq(rx_seq), .rx_ack_num(rx_ack_num),
      .send_syn(send_syn), .send_ack(send_ack), .tx_seq(tx_seq), .tx_ack_num(tx_ack_num),
      .established(established), .fail(fail)
   );

   tcp_client_handshake #(.SEQ_W(8), .CLIENT_ISN(255), .TIMEOUT_CYC(16), .MAX_RETRY(3)) u_wrap (
      .clk(clk), .reset(reset), .open_req(open_req2),
      .rx_valid(rx_valid), .rx_syn(rx_syn), .rx_ack(rx_ack), .rx_rst(rx_rst),
      .rx_seq(rx_seq), .rx_ack_num(rx_ack_num),
      .send_syn(w_send_syn), .send_ack(w_send_ack), .tx_seq(w_tx_seq), .tx_ack_num(w_tx_ack_num),
      .established(w_established), .fail(w_fail)
   );

   // Scoreboard monitor: every pulse must match the head of the queue exactly.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (send_syn === 1'b1 && send_ack === 1'b1) begin
         errors++;
         $display("FAIL both_pulses cyc=%0d send_syn=1 send_ack=1 required never together", cyc);
      end else if (send_syn === 1'b1 || send_ack === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d syn=%b ack=%b seq=%0d ack_num=%0d required none",
                     cyc, send_syn, send_ack, tx_seq, tx_ack_num);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (send_ack !== e.is_ack || cyc != e.cyc || tx_seq !== e.seq || tx_ack_num !== e.ack) begin
               errors++;
               $display("FAIL pulse got ack=%b cyc=%0d seq=%0d ack_num=%0d required ack=%b cyc=%0d seq=%0d ack_num=%0d",
                        send_ack, cyc, tx_seq, tx_ack_num, e.is_ack, e.cyc, e.seq, e.ack);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic goto(input int e);
      // Returns at the negedge just before posedge number e.
      while (cyc < e - 1) @(negedge clk);
   endtask

   task automatic drive_seg(input bit s, input bit a, input bit r, input int seq, input int ackn);
      rx_valid = 1'b1; rx_syn = s; rx_ack = a; rx_rst = r;
      rx_seq = 8'(seq); rx_ack_num = 8'(ackn);
   endtask

   task automatic clear_rx();
      rx_valid = 1'b0; rx_syn = 1'b0; rx_ack = 1'b0; rx_rst = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); @(negedge clk); reset = 1'b0;
   endtask

   task automatic start_open(output int t0);
      @(negedge clk); open_req = 1'b1; t0 = cyc + 1;
      q.push_back('{is_ack: 1'b0, cyc: t0, seq: 8'd100, ack: 8'd0});
      @(negedge clk); open_req = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({send_syn, send_ack, established, fail} !== 4'b0 || tx_seq !== 8'd0 || tx_ack_num !== 8'd0) begin
         errors++;
         $display("FAIL reset_state got syn=%b ack=%b est=%b fail=%b seq=%0d ack_num=%0d required all 0",
                  send_syn, send_ack, established, fail, tx_seq, tx_ack_num);
      end
   endtask

   task automatic test_nominal();
      int t0;
      start_open(t0);
      goto(t0 + 3);
      drive_seg(1, 1, 0, 200, 101);
      q.push_back('{is_ack: 1'b1, cyc: t0 + 3, seq: 8'd101, ack: 8'd201});
      @(negedge clk); clear_rx();
      checks++;
      if (established !== 1'b0) begin
         errors++; $display("FAIL nominal_est_early got %b required 0", established);
      end
      @(negedge clk);
      checks++;
      if (established !== 1'b1 || fail !== 1'b0) begin
         errors++; $display("FAIL nominal_est got est=%b fail=%b required 1 0", established, fail);
      end
      // open_req while established is ignored (monitor flags any pulse)
      open_req = 1'b1; repeat (4) @(negedge clk); open_req = 1'b0;
      checks++;
      if (established !== 1'b1 || tx_seq !== 8'd101 || tx_ack_num !== 8'd201) begin
         errors++; $display("FAIL nominal_hold got est=%b seq=%0d ack_num=%0d required 1 101 201",
                            established, tx_seq, tx_ack_num);
      end
   endtask

   task automatic test_bad_ack();
      int t0;
      do_reset();
      start_open(t0);
      goto(t0 + 3); drive_seg(1, 1, 0, 200, 150);   // wrong ack number
      @(negedge clk); drive_seg(1, 0, 0, 200, 101); // bare SYN
      @(negedge clk); clear_rx();
      q.push_back('{is_ack: 1'b0, cyc: t0 + 16, seq: 8'd100, ack: 8'd0});
      goto(t0 + 20);
      checks++;
      if (established !== 1'b0) begin
         errors++; $display("FAIL badack_ignored got est=%b required 0", established);
      end
      drive_seg(1, 1, 0, 50, 101);
      q.push_back('{is_ack: 1'b1, cyc: t0 + 20, seq: 8'd101, ack: 8'd51});
      @(negedge clk); clear_rx();
      @(negedge clk);
      checks++;
      if (established !== 1'b1) begin
         errors++; $display("FAIL badack_est got %b required 1", established);
      end
   endtask

   task automatic test_exhaust();
      int t0, t1;
      do_reset();
      start_open(t0);
      for (int k = 1; k <= 3; k++)
         q.push_back('{is_ack: 1'b0, cyc: t0 + 16 * k, seq: 8'd100, ack: 8'd0});
      goto(t0 + 64);
      checks++;
      if (fail !== 1'b0) begin
         errors++; $display("FAIL exhaust_early got fail=%b required 0", fail);
      end
      @(negedge clk);
      checks++;
      if (fail !== 1'b1 || established !== 1'b0) begin
         errors++; $display("FAIL exhaust_fail got fail=%b est=%b required 1 0", fail, established);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (fail !== 1'b1) begin
         errors++; $display("FAIL exhaust_hold got fail=%b required 1", fail);
      end
      open_req = 1'b1; t1 = cyc + 1;
      q.push_back('{is_ack: 1'b0, cyc: t1, seq: 8'd100, ack: 8'd0});
      @(negedge clk); open_req = 1'b0;
      checks++;
      if (fail !== 1'b0 || send_syn !== 1'b1) begin
         errors++; $display("FAIL exhaust_restart got fail=%b send_syn=%b required 0 1", fail, send_syn);
      end
   endtask

   task automatic test_collision();
      int t0;
      do_reset();
      start_open(t0);
      goto(t0 + 16);
      drive_seg(1, 1, 0, 7, 101);
      q.push_back('{is_ack: 1'b1, cyc: t0 + 16, seq: 8'd101, ack: 8'd8});
      @(negedge clk); clear_rx();
      @(negedge clk);
      checks++;
      if (established !== 1'b1) begin
         errors++; $display("FAIL collision_est got %b required 1", established);
      end
   endtask

   task automatic test_rst_reset();
      int t0, t1;
      // RST while established
      @(negedge clk); drive_seg(0, 0, 1, 0, 0);
      @(negedge clk); clear_rx();
      checks++;
      if (established !== 1'b0) begin
         errors++; $display("FAIL rst_est got est=%b required 0", established);
      end
      // RST beats a coincident match
      start_open(t0);
      goto(t0 + 3); drive_seg(1, 1, 1, 200, 101);
      @(negedge clk); clear_rx();
      @(negedge clk);
      checks++;
      if (established !== 1'b0 || fail !== 1'b0) begin
         errors++; $display("FAIL rst_prio got est=%b fail=%b required 0 0", established, fail);
      end
      // Back in CLOSED: a new open must be honoured
      start_open(t1);
      goto(t1 + 5); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      checks++;
      if ({send_syn, send_ack, established, fail} !== 4'b0 || tx_seq !== 8'd0 || tx_ack_num !== 8'd0) begin
         errors++; $display("FAIL reset_mid got syn=%b ack=%b est=%b fail=%b seq=%0d ack_num=%0d required all 0",
                            send_syn, send_ack, established, fail, tx_seq, tx_ack_num);
      end
      goto(t1 + 30);   // any stale retransmit would hit the monitor
   endtask

   task automatic test_wrap();
      do_reset();
      @(negedge clk); open_req2 = 1'b1;
      @(negedge clk); open_req2 = 1'b0;
      checks++;
      if (w_send_syn !== 1'b1 || w_tx_seq !== 8'd255 || w_tx_ack_num !== 8'd0) begin
         errors++; $display("FAIL wrap_syn got syn=%b seq=%0d ack_num=%0d required 1 255 0",
                            w_send_syn, w_tx_seq, w_tx_ack_num);
      end
      drive_seg(1, 1, 0, 255, 0);
      @(negedge clk); clear_rx();
      checks++;
      if (w_send_ack !== 1'b1 || w_send_syn !== 1'b0 || w_tx_seq !== 8'd0 || w_tx_ack_num !== 8'd0) begin
         errors++; $display("FAIL wrap_ack got ack=%b syn=%b seq=%0d ack_num=%0d required 1 0 0 0",
                            w_send_ack, w_send_syn, w_tx_seq, w_tx_ack_num);
      end
      @(negedge clk);
      checks++;
      if (w_established !== 1'b1 || w_send_ack !== 1'b0) begin
         errors++; $display("FAIL wrap_est got est=%b ack=%b required 1 0", w_established, w_send_ack);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_ack();
      test_exhaust();
      test_collision();
      test_rst_reset();
      test_wrap();
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
